// File: rtl/nibble_ram_writer.sv
// nibble_ram_writer
//   Writable 16x4 nibble store filled by a burst controller. A start command
//   captures a base address and a word count; words then arrive over a
//   valid/ready stream and land at consecutive addresses (wrapping). A
//   separate registered read port mirrors the lookup-ROM read interface
//   (one-cycle latency, zero output when not enabled).
//
// Ports
//   i_clk        clock, all logic on the rising edge
//   i_rst        synchronous active-high reset
//   i_start      begin a burst (only honoured in IDLE)
//   i_base_addr  first write address, captured with i_start
//   i_count      burst length, captured with i_start; 0 = no writes, >16 = 16
//   i_wr_valid   write word available
//   i_wr_data    write word
//   o_wr_ready   block accepts a word this cycle
//   o_busy       high while not IDLE
//   o_done       one-cycle pulse at burst end
//   i_en         read enable
//   i_addr       read address
//   o_data       registered read data
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for i_start, stream not ready
// WRITE | accepting words, one per valid cycle, until count exhausted
// DONE  | single-cycle end-of-burst pulse, returns to IDLE

module nibble_ram_writer #(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_base_addr,
   input  logic [ADDR_W:0]   i_count,
   input  logic              i_wr_valid,
   input  logic [DATA_W-1:0] i_wr_data,
   output logic              o_wr_ready,
   output logic              o_busy,
   output logic              o_done,
   input  logic              i_en,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] o_data
);

   localparam int            DEPTH     = 1 << ADDR_W;
   localparam logic [ADDR_W:0] MAX_COUNT = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE_LEFT  = (ADDR_W + 1)'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [ADDR_W-1:0]   r_ptr;
   logic [ADDR_W:0]     r_remaining;
   logic [DATA_W-1:0]   r_mem [DEPTH];
   logic [DATA_W-1:0]   r_data;
   logic [ADDR_W:0]     w_count_clamped;
   logic                w_accept_start;
   logic                w_xfer;

   assign w_count_clamped = (i_count > MAX_COUNT) ? MAX_COUNT : i_count;
   assign w_accept_start  = (r_state == ST_IDLE) && i_start;
   assign w_xfer          = (r_state == ST_WRITE) && i_wr_valid;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      o_wr_ready   = 1'b0;
      o_busy       = 1'b0;
      o_done       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               w_state_next = (w_count_clamped == '0) ? ST_DONE : ST_WRITE;
            end
         end
         ST_WRITE: begin
            o_wr_ready = 1'b1;
            o_busy     = 1'b1;
            if (i_wr_valid && (r_remaining == ONE_LEFT)) begin
               w_state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            o_done       = 1'b1;
            o_busy       = 1'b1;
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ptr       <= '0;
         r_remaining <= '0;
      end else if (w_accept_start) begin
         r_ptr       <= i_base_addr;
         r_remaining <= w_count_clamped;
      end else if (w_xfer) begin
         r_ptr       <= r_ptr + 1'b1;
         r_remaining <= r_remaining - 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_xfer) begin
         r_mem[r_ptr] <= i_wr_data;
      end
   end

   // Read samples the array before this edge's write lands, so a same-address
   // collision returns the old word.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_data <= '0;
      end else if (i_en) begin
         r_data <= r_mem[i_addr];
      end else begin
         r_data <= '0;
      end
   end

   assign o_data = r_data;

endmodule

// File: tb/tb_nibble_ram_writer.sv
module tb_nibble_ram_writer;

   logic       clk;
   logic       rst;
   logic       start;
   logic [3:0] base_addr;
   logic [4:0] count;
   logic       wr_valid;
   logic [3:0] wr_data;
   logic       wr_ready;
   logic       busy;
   logic       done;
   logic       en;
   logic [3:0] addr;
   logic [3:0] data;

   int n_checks = 0;
   int n_pass   = 0;

   // reference contents of the 16 nibbles
   logic [3:0] m_mem [16];

   nibble_ram_writer #(.DATA_W(4), .ADDR_W(4)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_start     (start),
      .i_base_addr (base_addr),
      .i_count     (count),
      .i_wr_valid  (wr_valid),
      .i_wr_data   (wr_data),
      .o_wr_ready  (wr_ready),
      .o_busy      (busy),
      .o_done      (done),
      .i_en        (en),
      .i_addr      (addr),
      .o_data      (data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      n_checks++;
      if ({busy, wr_ready, done} !== 3'b000) $display("FAIL reset_flags: got busy/ready/done=%b expected 000", {busy, wr_ready, done});
      else n_pass++;
      n_checks++;
      if (data !== 4'h0) $display("FAIL reset_data: got %h expected 0", data);
      else n_pass++;
      for (int k = 0; k < 16; k++) m_mem[k] = 4'h0;
      for (int k = 0; k < 16; k++) begin
         en = 1'b1; addr = 4'(k);
         tick();
         n_checks++;
         if (data !== 4'h0) $display("FAIL reset_mem[%0d]: got %h expected 0", k, data);
         else n_pass++;
      end
      en = 1'b0;
   endtask

   task automatic test_full_burst();
      int n;
      int k;
      base_addr = 4'd0; count = 5'd16; start = 1'b1;
      tick();
      start = 1'b0;
      n = 1;
      k = 0;
      n_checks++;
      if ({wr_ready, busy} !== 2'b11) $display("FAIL full_enter_write: got ready/busy=%b expected 11", {wr_ready, busy});
      else n_pass++;
      while (!done && n < 40) begin
         if (k < 16) begin
            wr_valid = 1'b1; wr_data = 4'(k);
            m_mem[k] = 4'(k);
            k++;
         end else begin
            wr_valid = 1'b0;
         end
         tick();
         n++;
      end
      wr_valid = 1'b0;
      // done lives in cycle N+17 when start was sampled in cycle N
      n_checks++;
      if (n !== 17) $display("FAIL full_done_latency: got %0d expected 17", n);
      else n_pass++;
      tick();
      n_checks++;
      if ({busy, done} !== 2'b00) $display("FAIL full_back_idle: got busy/done=%b expected 00", {busy, done});
      else n_pass++;
      for (int j = 0; j < 16; j++) begin
         en = 1'b1; addr = 4'(j);
         tick();
         n_checks++;
         if (data !== m_mem[j]) $display("FAIL full_readback[%0d]: got %h expected %h", j, data, m_mem[j]);
         else n_pass++;
      end
      en = 1'b0;
      tick();
      n_checks++;
      if (data !== 4'h0) $display("FAIL full_en_low: got %h expected 0", data);
      else n_pass++;
   endtask

   task automatic test_wrap_stalls();
      logic [3:0] w [4];
      for (int i = 0; i < 4; i++) w[i] = 4'($urandom);
      base_addr = 4'd14; count = 5'd4; start = 1'b1;
      tick();
      start = 1'b0;
      wr_valid = 1'b1; wr_data = w[0]; tick();
      wr_data = w[1]; tick();
      wr_valid = 1'b0;
      for (int s = 0; s < 2; s++) begin
         tick();
         n_checks++;
         if ({busy, wr_ready, done} !== 3'b110) $display("FAIL wrap_stall%0d: got busy/ready/done=%b expected 110", s, {busy, wr_ready, done});
         else n_pass++;
      end
      wr_valid = 1'b1; wr_data = w[2]; tick();
      n_checks++;
      if (done !== 1'b0) $display("FAIL wrap_early_done: got %b expected 0", done);
      else n_pass++;
      wr_data = w[3]; tick();
      wr_valid = 1'b0;
      n_checks++;
      if (done !== 1'b1) $display("FAIL wrap_done_after_d: got %b expected 1", done);
      else n_pass++;
      m_mem[14] = w[0]; m_mem[15] = w[1]; m_mem[0] = w[2]; m_mem[1] = w[3];
      tick();
      for (int j = 0; j < 16; j++) begin
         en = 1'b1; addr = 4'(j);
         tick();
         n_checks++;
         if (data !== m_mem[j]) $display("FAIL wrap_readback[%0d]: got %h expected %h", j, data, m_mem[j]);
         else n_pass++;
      end
      en = 1'b0;
   endtask

   task automatic test_zero_and_ignored_start();
      logic [3:0] w0, w1;
      w0 = 4'($urandom); w1 = 4'($urandom);
      base_addr = 4'($urandom); count = 5'd0; start = 1'b1;
      tick();
      start = 1'b0;
      n_checks++;
      if ({busy, wr_ready, done} !== 3'b101) $display("FAIL zero_done: got busy/ready/done=%b expected 101", {busy, wr_ready, done});
      else n_pass++;
      tick();
      n_checks++;
      if ({busy, done} !== 2'b00) $display("FAIL zero_idle: got busy/done=%b expected 00", {busy, done});
      else n_pass++;
      base_addr = 4'd3; count = 5'd2; start = 1'b1;
      tick();
      base_addr = 4'd9; count = 5'd5;
      wr_valid = 1'b1; wr_data = w0;
      tick();
      start = 1'b0;
      n_checks++;
      if ({busy, done} !== 2'b10) $display("FAIL ignored_start_midburst: got busy/done=%b expected 10", {busy, done});
      else n_pass++;
      wr_data = w1;
      tick();
      wr_valid = 1'b0;
      n_checks++;
      if (done !== 1'b1) $display("FAIL ignored_start_done: got %b expected 1", done);
      else n_pass++;
      m_mem[3] = w0; m_mem[4] = w1;
      tick();
      for (int j = 0; j < 16; j++) begin
         en = 1'b1; addr = 4'(j);
         tick();
         n_checks++;
         if (data !== m_mem[j]) $display("FAIL ignored_readback[%0d]: got %h expected %h", j, data, m_mem[j]);
         else n_pass++;
      end
      en = 1'b0;
   endtask

   task automatic test_collision();
      base_addr = 4'd5; count = 5'd1; start = 1'b1;
      tick();
      start = 1'b0;
      wr_valid = 1'b1; wr_data = 4'h3;
      tick();
      wr_valid = 1'b0;
      tick();
      m_mem[5] = 4'h3;
      base_addr = 4'd5; count = 5'd1; start = 1'b1;
      tick();
      start = 1'b0;
      wr_valid = 1'b1; wr_data = 4'hA; en = 1'b1; addr = 4'd5;
      tick();
      wr_valid = 1'b0;
      n_checks++;
      if (data !== 4'h3) $display("FAIL collision_old: got %h expected 3", data);
      else n_pass++;
      m_mem[5] = 4'hA;
      tick();
      n_checks++;
      if (data !== 4'hA) $display("FAIL collision_new: got %h expected a", data);
      else n_pass++;
      en = 1'b0;
      tick();
   endtask

   task automatic test_random_bursts();
      for (int it = 0; it < 6; it++) begin
         int cnt, eff, left, guard;
         logic [3:0] ptr;
         logic v;
         logic [3:0] d;
         cnt = $urandom_range(0, 20);
         eff = (cnt > 16) ? 16 : cnt;
         ptr = 4'($urandom);
         base_addr = ptr; count = 5'(cnt); start = 1'b1;
         tick();
         start = 1'b0;
         left = eff;
         guard = 0;
         while (left > 0 && guard < 200) begin
            n_checks++;
            if (wr_ready !== 1'b1) $display("FAIL rand%0d_ready: got %b expected 1 (left %0d)", it, wr_ready, left);
            else n_pass++;
            v = ($urandom_range(0, 2) != 0);
            d = 4'($urandom);
            wr_valid = v; wr_data = d;
            tick();
            guard++;
            if (v) begin
               m_mem[ptr] = d;
               ptr = ptr + 4'd1;
               left--;
            end
         end
         wr_valid = 1'b0;
         n_checks++;
         if (guard >= 200) $display("FAIL rand%0d_budget: got %0d cycles expected under 200", it, guard);
         else n_pass++;
         n_checks++;
         if (done !== 1'b1) $display("FAIL rand%0d_done: got %b expected 1 (count %0d)", it, done, cnt);
         else n_pass++;
         tick();
         n_checks++;
         if (busy !== 1'b0) $display("FAIL rand%0d_idle: got busy %b expected 0", it, busy);
         else n_pass++;
         for (int j = 0; j < 16; j++) begin
            en = 1'b1; addr = 4'(j);
            tick();
            n_checks++;
            if (data !== m_mem[j]) $display("FAIL rand%0d_readback[%0d]: got %h expected %h", it, j, data, m_mem[j]);
            else n_pass++;
         end
         en = 1'b0;
      end
   endtask

   task automatic test_reset_mid_burst();
      base_addr = 4'($urandom); count = 5'd8; start = 1'b1;
      tick();
      start = 1'b0;
      wr_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         wr_data = 4'($urandom);
         tick();
      end
      wr_data = 4'($urandom);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      wr_valid = 1'b0;
      for (int k = 0; k < 16; k++) m_mem[k] = 4'h0;
      n_checks++;
      if ({busy, wr_ready, done} !== 3'b000) $display("FAIL midrst_flags: got busy/ready/done=%b expected 000", {busy, wr_ready, done});
      else n_pass++;
      for (int s = 0; s < 3; s++) begin
         tick();
         n_checks++;
         if (done !== 1'b0) $display("FAIL midrst_no_done%0d: got %b expected 0", s, done);
         else n_pass++;
      end
      for (int j = 0; j < 16; j++) begin
         en = 1'b1; addr = 4'(j);
         tick();
         n_checks++;
         if (data !== m_mem[j]) $display("FAIL midrst_readback[%0d]: got %h expected %h", j, data, m_mem[j]);
         else n_pass++;
      end
      en = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; base_addr = '0; count = '0;
      wr_valid = 1'b0; wr_data = '0; en = 1'b0; addr = '0;
      test_reset();
      test_full_burst();
      test_wrap_stalls();
      test_zero_and_ignored_start();
      test_collision();
      test_random_bursts();
      test_reset_mid_burst();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
